// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with E0/F0 prefix decoding and show-ahead FIFO
`timescale 1ns/1ps
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE         = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          ovf_clr,
  output logic [7:0]                    data,
  output logic                          is_break,
  output logic                          is_ext,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} dec_state_t;

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [3:0]    bit_cnt;
  logic [9:0]    frame_bits;
  logic [TW-1:0] idle_cnt;
  logic          strobe;
  logic          frame_end;
  logic          frame_ok;
  logic          frame_bad;
  logic          timeout;
  logic [7:0]    rx_byte;

  // Data is synchronised too; it is stable for microseconds around the PS/2 clock edge.
  assign strobe    = clk_sync[2] & ~clk_sync[1];
  assign frame_end = strobe && (bit_cnt == 4'd10);
  assign frame_ok  = frame_end && !frame_bits[0] && data_sync[1] && (^frame_bits[9:1]);
  assign frame_bad = frame_end && !frame_ok;
  assign timeout   = !strobe && (bit_cnt != 4'd0) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rx_byte   = frame_bits[8:1];

  // Bits shift in at the top, so after ten strobes the start bit sits in frame_bits[0].
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync   <= 3'b111;
      data_sync  <= 2'b11;
      bit_cnt    <= 4'd0;
      frame_bits <= 10'd0;
      idle_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      err       <= frame_bad | timeout;
      if (strobe) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
        end else begin
          frame_bits <= {data_sync[1], frame_bits[9:1]};
          bit_cnt    <= bit_cnt + 4'd1;
        end
      end else if (timeout) begin
        bit_cnt  <= 4'd0;
        idle_cnt <= '0;
      end else if (bit_cnt != 4'd0) begin
        idle_cnt <= idle_cnt + TW'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  dec_state_t state;
  dec_state_t state_nxt;
  logic       push_req;
  logic [9:0] push_entry;

  always_comb begin
    state_nxt  = state;
    push_req   = 1'b0;
    push_entry = {2'b00, rx_byte};
    if (frame_bad || timeout) begin
      state_nxt = ST_IDLE;
    end else if (frame_ok) begin
      if (DECODE == 0) begin
        push_req = 1'b1;
      end else if (rx_byte == CODE_EXT) begin
        state_nxt = ST_E0;
      end else if (rx_byte == CODE_BRK) begin
        state_nxt = (state == ST_E0 || state == ST_E0F0) ? ST_E0F0 : ST_F0;
      end else begin
        push_req   = 1'b1;
        push_entry = {(state == ST_E0 || state == ST_E0F0),
                      (state == ST_F0 || state == ST_E0F0), rx_byte};
        state_nxt  = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] fill;
  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_push;
  logic        ovf_evt;
  logic [9:0]  head;

  assign fill    = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (fill == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_req && (!full || do_pop);
  assign ovf_evt = push_req && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
      if (ovf_evt)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign head     = empty ? 10'd0 : mem[rptr[AW-1:0]];
  assign data     = head[7:0];
  assign is_break = head[8];
  assign is_ext   = head[9];
  assign ready    = !empty;
  assign count    = fill;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int TOUT = 300;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       rd_raw = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [7:0] data, raw_data;
  logic       is_break, raw_break, is_ext, raw_ext;
  logic       ready, raw_ready, overflow, raw_overflow, err, raw_err;
  logic [3:0] count, raw_count;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int e0;
  logic [7:0] q[$];

  ps2_rx_fifo #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TOUT), .DECODE(1)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .data(data), .is_break(is_break),
    .is_ext(is_ext), .ready(ready), .count(count), .overflow(overflow), .err(err)
  );

  ps2_rx_fifo #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TOUT), .DECODE(0)) dut_raw (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_raw), .ovf_clr(1'b0), .data(raw_data), .is_break(raw_break),
    .is_ext(raw_ext), .ready(raw_ready), .count(raw_count), .overflow(raw_overflow),
    .err(raw_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit = 40 clk cycles; pop_at_stop raises rd_en on the push edge of the stop bit.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits, input bit pop_at_stop);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc(10);
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        wait_cyc(2);
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
        wait_cyc(17);
      end else begin
        wait_cyc(20);
      end
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b0, 11, 1'b0);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic pop_raw();
    rd_raw = 1'b1;
    wait_cyc(1);
    rd_raw = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(2);
  endtask

  initial begin
    wait_cyc(2);
    check("rst_ready", ready, 0);
    check("rst_count", count, 0);
    check("rst_data", data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err, 0);
    resetn = 1'b1;
    wait_cyc(2);

    // single plain code
    send(8'h1C);
    check("plain_ready", ready, 1);
    check("plain_data", data, 8'h1C);
    check("plain_brk", is_break, 0);
    check("plain_ext", is_ext, 0);
    check("plain_count", count, 1);
    pop();
    check("plain_pop_ready", ready, 0);
    check("plain_pop_data", data, 0);

    // prefix merge vs raw mode
    do_reset();
    send(8'hE0); send(8'hF0); send(8'h75);
    check("e0f0_count", count, 1);
    check("e0f0_data", data, 8'h75);
    check("e0f0_ext", is_ext, 1);
    check("e0f0_brk", is_break, 1);
    check("raw_count", raw_count, 3);
    check("raw_d0", {raw_ext, raw_break, raw_data}, 10'h0E0);
    pop_raw();
    check("raw_d1", {raw_ext, raw_break, raw_data}, 10'h0F0);
    pop_raw();
    check("raw_d2", {raw_ext, raw_break, raw_data}, 10'h075);
    pop();
    send(8'hF0); send(8'h1C);
    check("f0_count", count, 1);
    check("f0_entry", {is_ext, is_break, data}, 10'h11C);
    pop();

    // frame errors
    e0 = err_cnt;
    send_bits(8'h1C, 1'b1, 1'b0, 11, 1'b0);
    check("par_err", err_cnt - e0, 1);
    check("par_count", count, 0);
    e0 = err_cnt;
    send_bits(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    check("stop_err", err_cnt - e0, 1);
    check("stop_count", count, 0);
    e0 = err_cnt;
    send_bits(8'h1C, 1'b0, 1'b0, 5, 1'b0);
    wait_cyc(TOUT + 50);
    check("tout_err", err_cnt - e0, 1);
    check("tout_count", count, 0);
    e0 = err_cnt;
    send(8'h32);
    check("tout_next_data", data, 8'h32);
    check("tout_next_count", count, 1);
    check("tout_next_err", err_cnt - e0, 0);
    pop();

    // overflow: 0x10..0x18, the ninth is dropped
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_head", data, 8'h10);
    ovf_clr = 1'b1;
    wait_cyc(1);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    send_bits(8'h19, 1'b0, 1'b0, 11, 1'b1);
    check("full_pushpop_count", count, 8);
    check("full_pushpop_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), data, (i < 7) ? 8'h11 + 8'(i) : 8'h19);
      pop();
    end
    check("drain_empty", ready, 0);

    // wrap-around with interleaved pops against a queue model
    for (int i = 0; i < 20; i++) begin
      send(8'h20 + 8'(i));
      q.push_back(8'h20 + 8'(i));
      check($sformatf("wrap_cnt%0d", i), count, q.size());
      if (i % 3 == 2) begin
        repeat (2) begin
          check("wrap_data", data, q[0]);
          void'(q.pop_front());
          pop();
        end
      end
    end
    while (q.size() > 0) begin
      check("wrap_tail", data, q[0]);
      void'(q.pop_front());
      pop();
    end
    check("wrap_end_cnt", count, 0);

    // reset in the middle of a frame with an entry queued
    send(8'h1C);
    send_bits(8'h5A, 1'b0, 1'b0, 4, 1'b0);
    resetn = 1'b0;
    wait_cyc(1);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_data", {is_ext, is_break, data}, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_err", err, 0);
    wait_cyc(2);
    e0 = err_cnt;
    resetn = 1'b1;
    wait_cyc(2);
    send(8'h1C);
    check("post_rst_data", data, 8'h1C);
    check("post_rst_count", count, 1);
    check("post_rst_err", err_cnt - e0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
